// File: rtl/key_generator_pkg.sv
// key_generator_pkg: shared widths, LFSR taps, default seed and single-step function
package key_generator_pkg;

    localparam int KEY_W = 128;

    localparam int TAP_A = 127;
    localparam int TAP_B = 125;
    localparam int TAP_C = 100;
    localparam int TAP_D = 98;

    localparam logic [KEY_W-1:0] DEFAULT_SEED = 128'h1;

    // One Fibonacci step of x^128+x^126+x^101+x^99+1: shift left, feedback into bit 0
    function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] s);
        return {s[KEY_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/key_generator_lfsr.sv
// key_generator_lfsr: free-running 128-bit LFSR; KEYGEN_WIDE_STEP_EN selects 8 steps per clock
module key_generator_lfsr
    import key_generator_pkg::*;
#(
    parameter logic [KEY_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    output logic [KEY_W-1:0] state
);

`ifdef KEYGEN_WIDE_STEP_EN
    localparam int STEPS = 8;
`else
    localparam int STEPS = 1;
`endif

    // An all-zero seed would lock the register, so it falls back to the default
    localparam logic [KEY_W-1:0] INIT = (SEED == '0) ? DEFAULT_SEED : SEED;

    logic [KEY_W-1:0] state_q;
    logic [KEY_W-1:0] state_d;

    // Advance the state by STEPS unrolled single steps
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < STEPS; i++) state_d = lfsr_step(state_d);
    end

    // State register, reloaded with the seed on asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= INIT;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/key_generator.sv
// key_generator: seedable pseudo-random key source; ld snapshots the LFSR into rand_num (KEYGEN_WIDE_STEP_EN: 8 steps/clock)
module key_generator
    import key_generator_pkg::*;
#(
    parameter logic [KEY_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    output logic [KEY_W-1:0] rand_num
);

    logic [KEY_W-1:0] state;
    logic [KEY_W-1:0] rand_num_q;
    logic [KEY_W-1:0] rand_num_d;

    key_generator_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (state)
    );

    // Capture the pre-advance LFSR state on a load, otherwise hold
    always_comb begin
        rand_num_d = ld ? state : rand_num_q;
    end

    // Held key register, cleared on asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rand_num_q <= '0;
        else        rand_num_q <= rand_num_d;
    end

    assign rand_num = rand_num_q;

endmodule

// File: tb/tb_key_generator.sv
// tb_key_generator: directed self-checking bench for key_generator (honours KEYGEN_WIDE_STEP_EN)
module tb_key_generator;
    import key_generator_pkg::*;

`ifdef KEYGEN_WIDE_STEP_EN
    localparam int K = 8;
`else
    localparam int K = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ld = 1'b0;
    logic [KEY_W-1:0] rand_num;

    int passed = 0;
    int total = 0;

    key_generator #(.SEED(128'h1)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .rand_num (rand_num)
    );

    always #5 clk = ~clk;

    // Expected capture for a load at edge n while the single set bit is still below bit 98
    function automatic logic [KEY_W-1:0] exp_at(input int n);
        logic [KEY_W-1:0] one;
        one = 128'h1;
        return one << (K * (n - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ld = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        ld = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (rand_num !== 128'h0) $display("FAIL reset_async: got %h expected %h", rand_num, 128'h0);
        else passed++;
        tick();
        tick();
        total++;
        if (rand_num !== 128'h0) $display("FAIL reset_held: got %h expected %h", rand_num, 128'h0);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            total++;
            if (rand_num !== 128'h0) $display("FAIL idle_after_release edge %0d: got %h expected %h", n, rand_num, 128'h0);
            else passed++;
        end
    endtask

    task automatic test_load_edge10();
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            ld = (n == 10);
            tick();
        end
        ld = 1'b0;
        total++;
        if (rand_num !== exp_at(10)) $display("FAIL load_edge10: got %h expected %h", rand_num, exp_at(10));
        else passed++;
        for (int n = 0; n < 10; n++) begin
            tick();
            total++;
            if (rand_num !== exp_at(10)) $display("FAIL hold_after_load cycle %0d: got %h expected %h", n, rand_num, exp_at(10));
            else passed++;
        end
    endtask

    task automatic test_two_pulses();
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            ld = (n == 1) || (n == 12);
            tick();
            if (n == 1 || n == 6) begin
                total++;
                if (rand_num !== 128'h1) $display("FAIL pulse_edge1 at %0d: got %h expected %h", n, rand_num, 128'h1);
                else passed++;
            end
        end
        ld = 1'b0;
        total++;
        if (rand_num !== exp_at(12)) $display("FAIL pulse_edge12: got %h expected %h", rand_num, exp_at(12));
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            ld = (n >= 5);
            tick();
            if (n >= 5) begin
                total++;
                if (rand_num !== exp_at(n)) $display("FAIL back_to_back edge %0d: got %h expected %h", n, rand_num, exp_at(n));
                else passed++;
            end
        end
        ld = 1'b0;
        tick();
        total++;
        if (rand_num !== exp_at(7)) $display("FAIL back_to_back_hold: got %h expected %h", rand_num, exp_at(7));
        else passed++;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            ld = (n == 4);
            tick();
        end
        total++;
        if (rand_num !== exp_at(4)) $display("FAIL midrun_preload: got %h expected %h", rand_num, exp_at(4));
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (rand_num !== 128'h0) $display("FAIL midrun_async_clear: got %h expected %h", rand_num, 128'h0);
        else passed++;
        tick();
        total++;
        if (rand_num !== 128'h0) $display("FAIL midrun_load_discarded: got %h expected %h", rand_num, 128'h0);
        else passed++;
        ld = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ld = 1'b1;
        tick();
        ld = 1'b0;
        total++;
        if (rand_num !== 128'h1) $display("FAIL midrun_reload_edge1: got %h expected %h", rand_num, 128'h1);
        else passed++;
    endtask

`ifdef KEYGEN_WIDE_STEP_EN
    task automatic test_wide_step();
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            ld = (n == 3);
            tick();
        end
        ld = 1'b0;
        total++;
        if (rand_num !== 128'h10000) $display("FAIL wide_edge3: got %h expected %h", rand_num, 128'h10000);
        else passed++;
    endtask
`endif

    task automatic test_model();
        logic [KEY_W-1:0] m;
        logic [KEY_W-1:0] e;
        int bad;
        bad = 0;
        do_reset();
        m = 128'h1;
        ld = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            e = m;
            for (int j = 0; j < K; j++) m = lfsr_step(m);
            tick();
            total++;
            if (rand_num !== e) begin
                if (bad < 5) $display("FAIL model edge %0d: got %h expected %h", n, rand_num, e);
                bad++;
            end else passed++;
        end
        ld = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_edge10();
        test_two_pulses();
        test_back_to_back();
        test_reset_midrun();
`ifdef KEYGEN_WIDE_STEP_EN
        test_wide_step();
`endif
        test_model();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
